pgm_hdr_emitter: RTL and testbench

- Downstream stage of the packet-header update stage, inside the packet generation path.
- Owns the 64x128 ping-pong header RAM: two banks, each holding 8 headers of 4 words.
- Absorbs header-RAM writes from the update stage. On request, emits one stored header as a 134-bit FAST-format frame to the generator output.
- Reads only the bank selected by the update stage's address-shift flag, and latches that bank per packet so a bank flip never tears a frame.

---
 rtl/pgm_hdr_emitter_pkg.sv | 35 +++
 rtl/pgm_hdr_emitter_if.sv | 52 +++++
 rtl/hdr_ram_64x128.sv | 31 +++
 rtl/pgm_hdr_emitter.sv | 113 +++++++++++
 tb/tb_pgm_hdr_emitter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pgm_hdr_emitter_pkg.sv
// Shared constants for the packet header emitter.
// FAST frame codes, RAM geometry and FSM states.
package pgm_hdr_emitter_pkg;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 128;
  localparam int FRAME_W = 134;
  localparam int CNT_W   = 32;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } emit_state_e;

  // Frame code for a word given its position in the header.
  function automatic logic [1:0] fast_code(
    input logic first,
    input logic last
  );
    logic [1:0] c;
    c = MID;
    unique case (1'b1)
      first:   c = HEAD;
      last:    c = TAIL;
      default: c = MID;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pgm_hdr_emitter_if.sv
// Bundle between header update stage, emitter and generator.
// master drives requests and RAM writes; slave is the emitter.
interface pgm_hdr_emitter_if;
  import pgm_hdr_emitter_pkg::*;

  logic                  in_phu_pkt_hdr_wr;
  logic [ADDR_W-1:0]     in_phu_pkt_hdr_addr;
  logic [DATA_W-1:0]     in_phu_pkt_hdr;
  logic                  in_phu_addr_shift;
  logic                  in_phu_update_finish;
  logic                  in_pgm_req;
  logic [2:0]            in_pgm_hdr_idx;
  logic                  in_pgm_alf;
  logic                  out_pgm_req_ack;
  logic                  out_pgm_busy;
  logic [FRAME_W-1:0]    out_pgm_data;
  logic                  out_pgm_data_wr;
  logic [CNT_W-1:0]      out_pgm_pkt_cnt;

  modport master (
    output in_phu_pkt_hdr_wr,
    output in_phu_pkt_hdr_addr,
    output in_phu_pkt_hdr,
    output in_phu_addr_shift,
    output in_phu_update_finish,
    output in_pgm_req,
    output in_pgm_hdr_idx,
    output in_pgm_alf,
    input  out_pgm_req_ack,
    input  out_pgm_busy,
    input  out_pgm_data,
    input  out_pgm_data_wr,
    input  out_pgm_pkt_cnt
  );

  modport slave (
    input  in_phu_pkt_hdr_wr,
    input  in_phu_pkt_hdr_addr,
    input  in_phu_pkt_hdr,
    input  in_phu_addr_shift,
    input  in_phu_update_finish,
    input  in_pgm_req,
    input  in_pgm_hdr_idx,
    input  in_pgm_alf,
    output out_pgm_req_ack,
    output out_pgm_busy,
    output out_pgm_data,
    output out_pgm_data_wr,
    output out_pgm_pkt_cnt
  );

endinterface

// File: rtl/hdr_ram_64x128.sv
// Simple dual-port header RAM, registered read port.
// Read-during-write to one address returns the old word.
module hdr_ram_64x128 #(
  parameter int AW = 6,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pgm_hdr_emitter.sv
// Emits one stored packet header as a 4-word FAST frame.
// Bank is latched per frame so upstream flips never tear it.
module pgm_hdr_emitter
  import pgm_hdr_emitter_pkg::*;
#(
  parameter int HDR_NUM    = 8,
  parameter int HDR_WORDS  = 4,
  parameter bit CNT_INSERT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  pgm_hdr_emitter_if.slave  bus
);

  localparam int IDX_W = $clog2(HDR_NUM);
  localparam int WC_W  = $clog2(HDR_WORDS);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(HDR_WORDS - 1);

  emit_state_e      state_q;
  logic             bank_q;
  logic [IDX_W-1:0] idx_q;
  logic [WC_W-1:0]  wcnt_q;
  logic             busy_q;
  logic             wr_q;
  logic [1:0]       code_q;
  logic             tail_q;
  logic [CNT_W-1:0] cnt_q;

  logic              accept;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] payload;

  assign accept = (state_q == ST_IDLE)
                & bus.in_pgm_req
                & bus.in_phu_update_finish
                & ~bus.in_pgm_alf;

  assign ram_re    = (state_q == ST_READ);
  assign ram_raddr = {bank_q, idx_q, wcnt_q};

  hdr_ram_64x128 #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (bus.in_phu_pkt_hdr_wr),
    .waddr_i (bus.in_phu_pkt_hdr_addr),
    .wdata_i (bus.in_phu_pkt_hdr),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Frame sequencer: accept, issue four reads, drain last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bank_q  <= 1'b0;
      idx_q   <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      code_q  <= 2'b00;
      tail_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          wr_q   <= 1'b0;
          tail_q <= 1'b0;
          if (accept) begin
            state_q <= ST_READ;
            bank_q  <= bus.in_phu_addr_shift;
            idx_q   <= bus.in_pgm_hdr_idx[IDX_W-1:0];
            wcnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_READ: begin
          wcnt_q <= wcnt_q + 1'b1;
          wr_q   <= 1'b1;
          code_q <= fast_code(wcnt_q == '0, wcnt_q == WC_LAST);
          tail_q <= (wcnt_q == WC_LAST);
          if (wcnt_q == WC_LAST) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          wr_q    <= 1'b0;
          tail_q  <= 1'b0;
          cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Tail word optionally carries the pre-increment frame count.
  always_comb begin
    payload = ram_rdata;
    if (CNT_INSERT && tail_q) payload[CNT_W-1:0] = cnt_q;
  end

  assign bus.out_pgm_req_ack = accept;
  assign bus.out_pgm_busy    = busy_q;
  assign bus.out_pgm_data_wr = wr_q;
  assign bus.out_pgm_pkt_cnt = cnt_q;
  assign bus.out_pgm_data    = wr_q ? {code_q, 4'b0000, payload}
                                    : '0;

endmodule

// File: tb/tb_pgm_hdr_emitter.sv
// Directed bench for pgm_hdr_emitter.
// Hand-computed frames checked with immediate assertions.
module tb_pgm_hdr_emitter;
  import pgm_hdr_emitter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   fails = 0;

  pgm_hdr_emitter_if bus();

  pgm_hdr_emitter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [133:0] obs,
                     input logic [133:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] hv(input logic b,
                                      input logic [2:0] i,
                                      input logic [1:0] w);
    return {16'hC0DE, 7'd0, b, 5'd0, i, 6'd0, w,
            56'd0, 32'h1234_5600 + {30'd0, w}};
  endfunction

  task automatic wr_hdr(input logic b, input logic [2:0] i,
                        input logic [1:0] w);
    bus.in_phu_pkt_hdr_wr   = 1'b1;
    bus.in_phu_pkt_hdr_addr = {b, i, w};
    bus.in_phu_pkt_hdr      = hv(b, i, w);
    step();
    bus.in_phu_pkt_hdr_wr   = 1'b0;
  endtask

  // Called at the start of T0; drives the request itself.
  task automatic frame(input logic b, input logic [2:0] i,
                       input logic [31:0] c, input bit keep,
                       input bit flip);
    logic [127:0] pl;
    logic [1:0]   cd;
    logic [31:0]  cn;
    bus.in_pgm_req     = 1'b1;
    bus.in_pgm_hdr_idx = i;
    #1;
    chk("ack_t0", bus.out_pgm_req_ack, 1);
    step();
    if (!keep) bus.in_pgm_req = 1'b0;
    #1;
    chk("busy_t1", bus.out_pgm_busy, 1);
    chk("ack_t1", bus.out_pgm_req_ack, 0);
    chk("wr_t1", bus.out_pgm_data_wr, 0);
    for (int w = 0; w < 4; w++) begin
      step();
      if (flip && w == 0) bus.in_phu_addr_shift = 1'b0;
      #1;
      pl = hv(b, i, 2'(w));
      cd = (w == 0) ? 2'b01 : (w == 3) ? 2'b10 : 2'b11;
      if (w == 3) pl[31:0] = c;
      chk("wr_word", bus.out_pgm_data_wr, 1);
      chk("data_word", bus.out_pgm_data, {cd, 4'b0, pl});
      chk("busy_word", bus.out_pgm_busy, 1);
    end
    step();
    #1;
    cn = c + 32'd1;
    chk("wr_t6", bus.out_pgm_data_wr, 0);
    chk("data_t6", bus.out_pgm_data, 0);
    chk("busy_t6", bus.out_pgm_busy, 0);
    chk("cnt_t6", bus.out_pgm_pkt_cnt, cn);
  endtask

  initial begin
    bus.in_phu_pkt_hdr_wr    = 1'b0;
    bus.in_phu_pkt_hdr_addr  = '0;
    bus.in_phu_pkt_hdr       = '0;
    bus.in_phu_addr_shift    = 1'b1;
    bus.in_phu_update_finish = 1'b1;
    bus.in_pgm_req           = 1'b0;
    bus.in_pgm_hdr_idx       = 3'd0;
    bus.in_pgm_alf           = 1'b0;

    #12;
    chk("rst_wr", bus.out_pgm_data_wr, 0);
    chk("rst_busy", bus.out_pgm_busy, 0);
    chk("rst_data", bus.out_pgm_data, 0);
    chk("rst_cnt", bus.out_pgm_pkt_cnt, 0);
    chk("rst_ack", bus.out_pgm_req_ack, 0);
    rst_n = 1'b1;
    step();

    for (int w = 0; w < 4; w++) begin
      wr_hdr(1'b1, 3'd2, 2'(w));
      wr_hdr(1'b0, 3'd2, 2'(w));
    end

    frame(1'b1, 3'd2, 32'd0, 1'b0, 1'b0);

    frame(1'b1, 3'd2, 32'd1, 1'b1, 1'b0);
    frame(1'b1, 3'd2, 32'd2, 1'b1, 1'b0);
    frame(1'b1, 3'd2, 32'd3, 1'b0, 1'b0);

    frame(1'b1, 3'd2, 32'd4, 1'b0, 1'b1);
    frame(1'b0, 3'd2, 32'd5, 1'b0, 1'b0);

    bus.in_pgm_req = 1'b1;
    bus.in_pgm_alf = 1'b1;
    #1;
    chk("alf_noack", bus.out_pgm_req_ack, 0);
    step();
    bus.in_pgm_alf = 1'b0;
    bus.in_phu_update_finish = 1'b0;
    #1;
    chk("fin_noack", bus.out_pgm_req_ack, 0);
    chk("blk_busy", bus.out_pgm_busy, 0);
    step();
    chk("blk_wr", bus.out_pgm_data_wr, 0);
    bus.in_phu_update_finish = 1'b1;
    frame(1'b0, 3'd2, 32'd6, 1'b0, 1'b0);

    dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    chk("cnt_forced", bus.out_pgm_pkt_cnt, 32'hFFFF_FFFF);
    frame(1'b0, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);

    bus.in_pgm_req = 1'b1;
    #1;
    chk("rst_t0_ack", bus.out_pgm_req_ack, 1);
    step();
    bus.in_pgm_req = 1'b0;
    step();
    step();
    chk("pre_rst_wr", bus.out_pgm_data_wr, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", bus.out_pgm_data_wr, 0);
    chk("mid_rst_busy", bus.out_pgm_busy, 0);
    chk("mid_rst_cnt", bus.out_pgm_pkt_cnt, 0);
    chk("mid_rst_data", bus.out_pgm_data, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_wr", bus.out_pgm_data_wr, 0);
    frame(1'b0, 3'd2, 32'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
